// File: rtl/inst_loader.sv
// Instruction-BRAM loader: assembles a big-endian byte stream (word-count header
// followed by program words) into 32-bit BRAM writes, then acknowledges the host.
module inst_loader #(
    parameter int          ADDR_W    = 14,
    parameter logic [2:0]  LOAD_MODE = 3'd1,
    parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        mode,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic              bram_we,
    output logic [31:0]       word_count,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_ACK,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [32:0]     CAPACITY = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE  = 1;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [31:0]       word_count_q, word_count_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [31:0]       bram_din_q, bram_din_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              byte_accept;
    logic              last_byte;
    logic [31:0]       assembled;
    logic [ADDR_W:0]   idx_next;
    logic              last_word;

    assign byte_accept = rx_valid && (mode == LOAD_MODE) &&
                         ((state_q == S_HDR) || (state_q == S_DATA));
    assign last_byte   = byte_accept && (byte_cnt_q == 2'd3);
    assign assembled   = {shift_q, rx_data};
    assign idx_next    = word_idx_q + IDX_ONE;
    // Word index is one bit wider than the address so N == 2**ADDR_W terminates.
    assign last_word   = (32'(idx_next) == word_count_q);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs regardless of statement order.
        if (!rstn) state_q <= S_HDR;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_HDR: begin
                if (last_byte) begin
                    if (assembled == 32'd0)                  state_d = S_ACK;
                    else if ({1'b0, assembled} > CAPACITY)   state_d = S_ERR;
                    else                                     state_d = S_DATA;
                end
            end
            S_DATA: if (last_byte && last_word) state_d = S_ACK;
            S_ACK:  if (!tx_busy)               state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_HDR;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_idx_d   = word_idx_q;
        word_count_d = word_count_q;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        done_d       = done_q | (state_q == S_DONE);
        error_d      = error_q | (state_d == S_ERR);

        if (byte_accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = assembled[23:0];
        end

        if (last_byte && (state_q == S_HDR)) word_count_d = assembled;

        if (last_byte && (state_q == S_DATA)) begin
            bram_we_d   = 1'b1;
            bram_addr_d = word_idx_q[ADDR_W-1:0];
            bram_din_d  = assembled;
            word_idx_d  = idx_next;
        end

        if ((state_q == S_ACK) && !tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = ACK_BYTE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            word_idx_q   <= '0;
            word_count_q <= '0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_idx_q   <= word_idx_d;
            word_count_q <= word_count_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;
    assign bram_we    = bram_we_q;
    assign word_count = word_count_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction BRAM.
- Receives the program image as a byte stream from the UART receiver while the core is in LOAD mode.
- Assembles 32-bit big-endian words and writes them sequentially into INST_BRAM port A.
- When the last word is written, sends a one-byte acknowledge to the UART transmitter and asserts done. The fetch unit then copies BRAM into its instruction memory.

Parameters:
- ADDR_W, 14, BRAM word-address width (capacity 2**ADDR_W words).
- LOAD_MODE, 1, mode encoding in which byte reception is enabled.
- ACK_BYTE, 8'hAA, byte sent to the host after a successful load.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- mode  in  3  core mode; bytes are accepted only when mode == LOAD_MODE
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle pulse, send tx_data
- tx_data  out  8  byte to transmit
- bram_addr  out  ADDR_W  BRAM write address
- bram_din  out  32  BRAM write data
- bram_we  out  1  BRAM write enable
- word_count  out  32  header value N (number of program words)
- done  out  1  load complete, sticky
- error  out  1  header exceeded capacity, sticky

Behaviour:
- Reset (synchronous, rstn low at posedge clk): state=HDR; tx_start=0, tx_data=0, bram_addr=0, bram_din=0, bram_we=0, word_count=0, done=0, error=0; byte counter=0, word index=0.
- Byte acceptance: a byte is accepted only on a cycle with rx_valid=1 and mode==LOAD_MODE, and state is HDR or DATA. Bytes arriving in any other state or mode are dropped.
- Leaving LOAD mode pauses reception only; the state, byte counter and partial word are retained.
- Byte order: big-endian. The first byte of each group of 4 is bits [31:24]. A 2-bit byte counter wraps 3->0.
- HDR: collects 4 bytes into word_count.
  - On the 4th byte, word_count is registered.
  - If N == 0: go to ACK.
  - Else if N > 2**ADDR_W: go to ERR.
  - Else: go to DATA.
- DATA: collects 4 bytes per word.
  - On the cycle after the 4th byte is accepted: bram_we=1 for exactly one cycle, bram_din=assembled word, bram_addr=word index.
  - The word index increments after each write.
  - The write following word N-1 moves the state to ACK; that transition is registered on the same edge as the final bram_we.
  - bram_we is 0 in all other cycles.
  - bram_addr holds its last value between writes.
- ACK: wait while tx_busy=1. On the first cycle with tx_busy=0, pulse tx_start=1 for one cycle with tx_data=ACK_BYTE, then go to DONE.
- DONE: done=1 and stays high until reset. No further writes or transmits.
- ERR: error=1 and stays high until reset. No BRAM writes and no ack byte; all bytes are ignored.
- Latency:
  - last byte of a word to bram_we: 1 cycle;
  - final write to tx_start: 1 cycle minimum (more if tx_busy is high);
  - tx_start to done: 1 cycle.
- Boundaries:
  - N == 2**ADDR_W is legal and fills addresses 0..2**ADDR_W-1.
  - Word index width is ADDR_W+1 so that it compares against N without wrapping.
  - rx_valid on the same cycle as a bram_we is accepted normally, so back-to-back bytes are never lost.
  - rstn low mid-load aborts immediately. Outputs return to reset values; words already written to the BRAM are not cleared.

Test Plan:
- mode=1, bytes 00 00 00 02, DE AD BE EF, 01 23 45 67 -> bram_we pulses twice: addr 0 data 32'hDEADBEEF, then addr 1 data 32'h01234567; tx_start with tx_data=8'hAA; done=1; word_count=2.
- Header 00 00 00 00 -> no bram_we; tx_start/8'hAA; done=1.
- Header N=2**ADDR_W+1 (ADDR_W=4: 00 00 00 11) -> error=1, no bram_we, no tx_start; subsequent bytes ignored.
- mode=0 during the bytes of word 0, then mode=1 -> dropped bytes leave no trace; the words written match only the bytes received while mode=1.
- After the last word, hold tx_busy=1 for 50 cycles -> tx_start stays 0 until tx_busy falls, then a single one-cycle pulse; done follows 1 cycle later.
- Reset asserted after 5 data bytes of N=3 -> all outputs return to reset values; a fresh full stream (header N=1, then one word) then loads correctly to address 0.
